// File: rtl/gigatron_loader_pkg.sv
// rtl/gigatron_loader_pkg.sv - shared types and constants for the Gigatron boot loader
package gigatron_loader_pkg;

  typedef enum logic [2:0] {
    ST_RELEASE,
    ST_IDLE,
    ST_HDR,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_CSUM,
    ST_ERROR
  } state_e;

  localparam logic [7:0] START_BYTE_DEFAULT = 8'hA5;

  // addr_hi, addr_lo, cnt_hi, cnt_lo
  localparam int HDR_LEN = 4;

endpackage

// File: rtl/gigatron_loader.sv
// rtl/gigatron_loader.sv - byte-stream ROM loader that holds the Gigatron CPU in reset while loading
module gigatron_loader
  import gigatron_loader_pkg::*;
#(
  parameter int         ROM_ADDR_WIDTH    = 16,
  parameter int         RESET_HOLD_CYCLES = 4,
  parameter logic [7:0] START_BYTE        = START_BYTE_DEFAULT
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_rx_valid,
  output logic                      o_rx_ready,
  output logic                      o_cpu_reset,
  output logic                      o_rom_we,
  output logic [ROM_ADDR_WIDTH-1:0] o_rom_addr,
  output logic [15:0]               o_rom_wdata,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error
);

  localparam int HOLD_W = (RESET_HOLD_CYCLES < 2) ? 1 : $clog2(RESET_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [1:0] HDR_LAST = 2'(HDR_LEN - 1);

  state_e                    state_q, state_d;
  logic [1:0]                idx_q, idx_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [7:0]                sum_q, sum_d;
  logic [7:0]                byte_q, byte_d;
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic                      pend_q, pend_d;
  logic [ROM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]               wdata_q, wdata_d;
  logic                      we_q, we_d;
  logic                      cpu_reset_q, cpu_reset_d;
  logic                      rx_ready_q, rx_ready_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;

  logic                      accept;
  logic [7:0]                sum_next;
  logic [15:0]               cnt_shift;

  assign accept    = i_rx_valid && rx_ready_q;
  assign sum_next  = sum_q + i_rx_data;
  assign cnt_shift = {cnt_q[7:0], i_rx_data};

  // Next-state and next-output computation; all outputs are registered from state_d
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    byte_d  = byte_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = done_q;

    // The address advances on the edge after each write strobe
    if (we_q) begin
      addr_d = addr_q + 1'b1;
    end

    case (state_q)
      ST_RELEASE: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          // Only a successful frame (not power-on) reports done
          done_d  = pend_q;
          pend_d  = 1'b0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_IDLE, ST_ERROR: begin
        if (accept && (i_rx_data == START_BYTE)) begin
          state_d = ST_HDR;
          idx_d   = 2'd0;
          sum_d   = 8'h00;
          done_d  = 1'b0;
          pend_d  = 1'b0;
        end
      end
      ST_HDR: begin
        if (accept) begin
          sum_d = sum_next;
          idx_d = idx_q + 1'b1;
          case (idx_q)
            2'd0: byte_d = i_rx_data;
            2'd1: addr_d = ROM_ADDR_WIDTH'({byte_q, i_rx_data});
            default: cnt_d = cnt_shift;
          endcase
          if (idx_q == HDR_LAST) begin
            state_d = (cnt_shift == 16'd0) ? ST_CSUM : ST_DATA_LO;
          end
        end
      end
      ST_DATA_LO: begin
        if (accept) begin
          sum_d   = sum_next;
          byte_d  = i_rx_data;
          state_d = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (accept) begin
          sum_d   = sum_next;
          wdata_d = {i_rx_data, byte_q};
          we_d    = 1'b1;
          cnt_d   = cnt_q - 1'b1;
          state_d = (cnt_q == 16'd1) ? ST_CSUM : ST_DATA_LO;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (sum_next == 8'h00) begin
            state_d = ST_RELEASE;
            hold_d  = '0;
            pend_d  = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      default: state_d = ST_RELEASE;
    endcase

    cpu_reset_d = (state_d != ST_IDLE);
    rx_ready_d  = (state_d != ST_RELEASE);
    busy_d      = (state_d == ST_HDR) || (state_d == ST_DATA_LO) ||
                  (state_d == ST_DATA_HI) || (state_d == ST_CSUM);
    error_d     = (state_d == ST_ERROR);
  end

  // State and output registers; reset discards any partial frame immediately
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_RELEASE;
      idx_q       <= 2'd0;
      cnt_q       <= 16'd0;
      sum_q       <= 8'h00;
      byte_q      <= 8'h00;
      hold_q      <= '0;
      pend_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 16'h0000;
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      byte_q      <= byte_d;
      hold_q      <= hold_d;
      pend_q      <= pend_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cpu_reset_q <= cpu_reset_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign o_rx_ready  = rx_ready_q;
  assign o_cpu_reset = cpu_reset_q;
  assign o_rom_we    = we_q;
  assign o_rom_addr  = addr_q;
  assign o_rom_wdata = wdata_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_error     = error_q;

endmodule

// File: tb/tb_gigatron_loader.sv
// tb/tb_gigatron_loader.sv - self-checking bench for gigatron_loader
module tb_gigatron_loader;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        o_rx_ready;
  logic        o_cpu_reset;
  logic        o_rom_we;
  logic [15:0] o_rom_addr;
  logic [15:0] o_rom_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_error;

  gigatron_loader dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_rx_ready  (o_rx_ready),
    .o_cpu_reset (o_cpu_reset),
    .o_rom_we    (o_rom_we),
    .o_rom_addr  (o_rom_addr),
    .o_rom_wdata (o_rom_wdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error)
  );

  always #5 i_clock = ~i_clock;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] cnt;
    logic [15:0] w0;
    logic [15:0] w1;
    logic        bad;
    logic        exp_done;
    logic        exp_error;
  } vec_t;

  wr_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] tb_sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Advance to the next falling edge and consume any write strobe seen there
  task automatic tick();
    wr_t w;
    @(negedge i_clock);
    if (o_rom_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        w = exp_q.pop_front();
        chk("wr_addr", {16'h0, o_rom_addr}, {16'h0, w.addr});
        chk("wr_data", {16'h0, o_rom_wdata}, {16'h0, w.data});
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    while (!o_rx_ready && n < 50) begin
      tick();
      n++;
    end
    if (!o_rx_ready) chk("ready_timeout", 32'd0, 32'd1);
    tick();
    i_rx_valid = 1'b0;
    tb_sum = tb_sum + b;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_reset"}, {31'h0, o_cpu_reset}, 32'd1);
    chk({tag, "_we"},        {31'h0, o_rom_we},    32'd0);
    chk({tag, "_addr"},      {16'h0, o_rom_addr},  32'd0);
    chk({tag, "_wdata"},     {16'h0, o_rom_wdata}, 32'd0);
    chk({tag, "_busy"},      {31'h0, o_busy},      32'd0);
    chk({tag, "_done"},      {31'h0, o_done},      32'd0);
    chk({tag, "_error"},     {31'h0, o_error},     32'd0);
    chk({tag, "_rx_ready"},  {31'h0, o_rx_ready},  32'd0);
  endtask

  task automatic run_frame(input vec_t v);
    logic [15:0] w;
    logic [7:0]  cs;
    send(8'hA5);
    chk("busy_hdr", {31'h0, o_busy}, 32'd1);
    chk("done_clr", {31'h0, o_done}, 32'd0);
    chk("cpu_reset_hdr", {31'h0, o_cpu_reset}, 32'd1);
    tb_sum = 8'h00;
    send(v.addr[15:8]);
    send(v.addr[7:0]);
    send(v.cnt[15:8]);
    send(v.cnt[7:0]);
    for (int i = 0; i < int'(v.cnt); i++) begin
      w = (i == 0) ? v.w0 : v.w1;
      send(w[7:0]);
      exp_q.push_back('{addr: v.addr + 16'(i), data: w});
      send(w[15:8]);
    end
    cs = 8'h00 - tb_sum;
    if (v.bad) cs = cs - 8'h01;
    send(cs);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("rel_cpu_reset", {31'h0, o_cpu_reset}, (v.bad || k < 4) ? 32'd1 : 32'd0);
      chk("rel_rx_ready", {31'h0, o_rx_ready}, (v.bad || k == 4) ? 32'd1 : 32'd0);
    end
    chk("frame_done", {31'h0, o_done}, {31'h0, v.exp_done});
    chk("frame_error", {31'h0, o_error}, {31'h0, v.exp_error});
    chk("frame_busy", {31'h0, o_busy}, 32'd0);
    chk("writes_pending", exp_q.size(), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{addr: 16'h0100, cnt: 16'd2, w0: 16'h1234, w1: 16'h5678, bad: 1'b0, exp_done: 1'b1, exp_error: 1'b0};
    vecs[1] = '{addr: 16'h0100, cnt: 16'd2, w0: 16'h1234, w1: 16'h5678, bad: 1'b1, exp_done: 1'b0, exp_error: 1'b1};
    vecs[2] = '{addr: 16'h0200, cnt: 16'd1, w0: 16'hABCD, w1: 16'h0000, bad: 1'b0, exp_done: 1'b1, exp_error: 1'b0};
    vecs[3] = '{addr: 16'hFFFF, cnt: 16'd2, w0: 16'hA5A5, w1: 16'h0001, bad: 1'b0, exp_done: 1'b1, exp_error: 1'b0};
    vecs[4] = '{addr: 16'h0010, cnt: 16'd0, w0: 16'h0000, w1: 16'h0000, bad: 1'b0, exp_done: 1'b1, exp_error: 1'b0};
    tb_sum = 8'h00;

    repeat (3) tick();
    chk_reset_vals("rst");
    i_reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("boot_cpu_reset", {31'h0, o_cpu_reset}, (k < 4) ? 32'd1 : 32'd0);
      chk("boot_rx_ready", {31'h0, o_rx_ready}, (k == 4) ? 32'd1 : 32'd0);
    end

    // Non-start bytes in IDLE are swallowed
    send(8'h33);
    chk("idle_junk_busy", {31'h0, o_busy}, 32'd0);
    chk("idle_junk_cpu_reset", {31'h0, o_cpu_reset}, 32'd0);

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Reset between the two bytes of a data pair
    send(8'hA5);
    send(8'h03);
    send(8'h00);
    send(8'h00);
    send(8'h01);
    send(8'h77);
    i_reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    tick();
    tick();
    chk("midrst_held_we", {31'h0, o_rom_we}, 32'd0);
    i_reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("midrst_cpu_reset", {31'h0, o_cpu_reset}, (k < 4) ? 32'd1 : 32'd0);
    end
    chk("midrst_done", {31'h0, o_done}, 32'd0);
    chk("midrst_pending", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
